// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: turns one translated pipeline access at a time into a request
// on either the cached (dcache) or uncached (bus) path. It waits for the
// address accept and then the data return, and reports completion with a
// one-cycle resp_valid pulse. A flush cancels the access. If the slave has
// already taken the address, the controller still waits for the data return
// in DROP and then discards it.
module mem_req_ctrl (
    input  logic        clk,
    input  logic        resetn,

    // pipeline request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    input  logic [31:0] phy_addr,
    input  logic [1:0]  mat,
    input  logic        flush,

    // cached path (dcache)
    output logic        dc_req,
    output logic        dc_wr,
    output logic [1:0]  dc_size,
    output logic [3:0]  dc_wstrb,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    input  logic        dc_addr_ok,
    input  logic        dc_data_ok,
    input  logic [31:0] dc_rdata,

    // uncached path (system bus)
    output logic        uc_req,
    output logic        uc_wr,
    output logic [1:0]  uc_size,
    output logic [3:0]  uc_wstrb,
    output logic [31:0] uc_addr,
    output logic [31:0] uc_wdata,
    input  logic        uc_addr_ok,
    input  logic        uc_data_ok,
    input  logic [31:0] uc_rdata,

    // completion
    output logic        resp_valid,
    output logic [31:0] resp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_e;

    // Coherent-cached is the only memory type that goes to the dcache.
    localparam logic [1:0] MAT_CACHED = 2'b01;

    state_e      state_q, state_d;

    // Captured request fields. They only change on a handshake, so the
    // request stays stable until the slave accepts it.
    logic        wr_q,     wr_d;
    logic [1:0]  size_q,   size_d;
    logic [3:0]  wstrb_q,  wstrb_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] addr_q,   addr_d;
    logic        cached_q, cached_d;

    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept;
    logic        sel_addr_ok;
    logic        sel_data_ok;
    logic [31:0] sel_rdata;
    logic        in_req;

    // Only the path chosen at handshake time is listened to; strobes on the
    // other path are ignored.
    always_comb begin
        sel_addr_ok = cached_q ? dc_addr_ok : uc_addr_ok;
        sel_data_ok = cached_q ? dc_data_ok : uc_data_ok;
        sel_rdata   = cached_q ? dc_rdata   : uc_rdata;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Once the address is taken, data will come back, so a flush
                // in this cycle must still drain it through DROP.
                if (sel_addr_ok) begin
                    state_d = flush ? S_DROP : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (sel_data_ok) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (sel_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake ready and per-path request strobes.
    always_comb begin
        req_ready = (state_q == S_IDLE) && !flush;
        accept    = req_valid && req_ready;
        in_req    = (state_q == S_REQ);
        dc_req    = in_req && cached_q;
        uc_req    = in_req && !cached_q;
    end

    // Capture the request fields and the path select on a handshake.
    always_comb begin
        wr_d     = wr_q;
        size_d   = size_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        cached_d = cached_q;
        if (accept) begin
            wr_d     = req_wr;
            size_d   = req_size;
            wstrb_d  = req_wstrb;
            wdata_d  = req_wdata;
            addr_d   = phy_addr;
            cached_d = (mat == MAT_CACHED);
        end
    end

    // Request field registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            addr_q   <= 32'd0;
            cached_q <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            size_q   <= size_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            cached_q <= cached_d;
        end
    end

    // Both paths see the same registered fields; only the req strobe differs.
    always_comb begin
        dc_wr    = wr_q;
        dc_size  = size_q;
        dc_wstrb = wstrb_q;
        dc_addr  = addr_q;
        dc_wdata = wdata_q;
        uc_wr    = wr_q;
        uc_size  = size_q;
        uc_wstrb = wstrb_q;
        uc_addr  = addr_q;
        uc_wdata = wdata_q;
    end

    // Completion: only an unflushed data return in WAIT produces a response.
    // The data is zero outside the pulse and for stores.
    always_comb begin
        resp_valid_d = (state_q == S_WAIT) && sel_data_ok && !flush;
        resp_rdata_d = 32'd0;
        if (resp_valid_d && !wr_q) begin
            resp_rdata_d = sel_rdata;
        end
    end

    // Response registers. The pulse is one cycle because the FSM leaves WAIT
    // in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl. Inputs are driven on the falling edge,
// and outputs are checked 1 ns later.
module tb_mem_req_ctrl;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [31:0] phy_addr;
    logic [1:0]  mat;
    logic        flush;
    logic        dc_req, dc_wr;
    logic [1:0]  dc_size;
    logic [3:0]  dc_wstrb;
    logic [31:0] dc_addr, dc_wdata;
    logic        dc_addr_ok, dc_data_ok;
    logic [31:0] dc_rdata;
    logic        uc_req, uc_wr;
    logic [1:0]  uc_size;
    logic [3:0]  uc_wstrb;
    logic [31:0] uc_addr, uc_wdata;
    logic        uc_addr_ok, uc_data_ok;
    logic [31:0] uc_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    int tests_run;
    int tests_failed;

    mem_req_ctrl dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .phy_addr(phy_addr), .mat(mat), .flush(flush),
        .dc_req(dc_req), .dc_wr(dc_wr), .dc_size(dc_size), .dc_wstrb(dc_wstrb),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_addr_ok(dc_addr_ok),
        .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
        .uc_req(uc_req), .uc_wr(uc_wr), .uc_size(uc_size), .uc_wstrb(uc_wstrb),
        .uc_addr(uc_addr), .uc_wdata(uc_wdata), .uc_addr_ok(uc_addr_ok),
        .uc_data_ok(uc_data_ok), .uc_rdata(uc_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        req_valid  = 1'b0;  req_wr    = 1'b0;  req_size = 2'd0;
        req_wstrb  = 4'd0;  req_wdata = 32'd0; phy_addr = 32'd0;
        mat        = 2'd0;  flush     = 1'b0;
        dc_addr_ok = 1'b0;  dc_data_ok = 1'b0; dc_rdata = 32'd0;
        uc_addr_ok = 1'b0;  uc_data_ok = 1'b0; uc_rdata = 32'd0;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input logic [31:0] addr, input logic [1:0] m);
        req_valid = 1'b1; req_wr = wr; req_size = size; req_wstrb = wstrb;
        req_wdata = wdata; phy_addr = addr; mat = m;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        clear_inputs();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dc_req",     32'(dc_req), 32'd0);
        chk("rst_uc_req",     32'(uc_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_dc_addr",    dc_addr, 32'd0);
        chk("rst_req_ready",  32'(req_ready), 32'd1);
        @(negedge clk); resetn = 1'b1;

        // Cached load: handshake in slot 0, addr_ok in slot 2, data_ok in slot 4
        @(negedge clk); issue(1'b0, 2'd2, 4'hF, 32'd0, 32'h1C00_0100, 2'b01); #1;
        chk("ld_c0_ready",  32'(req_ready), 32'd1);
        chk("ld_c0_dc_req", 32'(dc_req), 32'd0);
        @(negedge clk); clear_inputs(); #1;
        chk("ld_c1_dc_req", 32'(dc_req), 32'd1);
        chk("ld_c1_uc_req", 32'(uc_req), 32'd0);
        chk("ld_c1_addr",   dc_addr, 32'h1C00_0100);
        chk("ld_c1_wr",     32'(dc_wr), 32'd0);
        chk("ld_c1_ready",  32'(req_ready), 32'd0);
        @(negedge clk); dc_addr_ok = 1'b1; #1;
        chk("ld_c2_dc_req", 32'(dc_req), 32'd1);
        @(negedge clk); dc_addr_ok = 1'b0; #1;
        chk("ld_c3_dc_req", 32'(dc_req), 32'd0);
        chk("ld_c3_uc_req", 32'(uc_req), 32'd0);
        @(negedge clk); dc_data_ok = 1'b1; dc_rdata = 32'hDEAD_BEEF; #1;
        chk("ld_c4_resp",   32'(resp_valid), 32'd0);
        @(negedge clk); clear_inputs(); #1;
        chk("ld_c5_resp",   32'(resp_valid), 32'd1);
        chk("ld_c5_rdata",  resp_rdata, 32'hDEAD_BEEF);
        chk("ld_c5_ready",  32'(req_ready), 32'd1);
        @(negedge clk); #1;
        chk("ld_c6_resp",   32'(resp_valid), 32'd0);
        chk("ld_c6_rdata",  resp_rdata, 32'd0);

        // Uncached store; inputs change after handshake, stray dc strobes ignored
        @(negedge clk); issue(1'b1, 2'd2, 4'b0011, 32'h1234_5678, 32'hBFAF_F000, 2'b00); #1;
        @(negedge clk); clear_inputs(); req_wdata = 32'hFFFF_FFFF; phy_addr = 32'h0; dc_addr_ok = 1'b1; #1;
        chk("st_c1_uc_req", 32'(uc_req), 32'd1);
        chk("st_c1_dc_req", 32'(dc_req), 32'd0);
        chk("st_c1_addr",   uc_addr, 32'hBFAF_F000);
        chk("st_c1_wdata",  uc_wdata, 32'h1234_5678);
        chk("st_c1_wstrb",  32'(uc_wstrb), 32'h3);
        chk("st_c1_wr",     32'(uc_wr), 32'd1);
        @(negedge clk); dc_addr_ok = 1'b0; #1;
        chk("st_c2_uc_req", 32'(uc_req), 32'd1);
        chk("st_c2_addr",   uc_addr, 32'hBFAF_F000);
        chk("st_c2_wdata",  uc_wdata, 32'h1234_5678);
        @(negedge clk); uc_addr_ok = 1'b1; #1;
        chk("st_c3_uc_req", 32'(uc_req), 32'd1);
        @(negedge clk); uc_addr_ok = 1'b0; dc_data_ok = 1'b1; dc_rdata = 32'h5555_5555; #1;
        chk("st_c4_uc_req", 32'(uc_req), 32'd0);
        @(negedge clk); dc_data_ok = 1'b0; uc_data_ok = 1'b1; uc_rdata = 32'hFFFF_FFFF; #1;
        chk("st_c5_resp",   32'(resp_valid), 32'd0);
        @(negedge clk); clear_inputs(); #1;
        chk("st_c6_resp",   32'(resp_valid), 32'd1);
        chk("st_c6_rdata",  resp_rdata, 32'd0);

        // Flush in IDLE blocks the handshake
        @(negedge clk); issue(1'b0, 2'd2, 4'hF, 32'd0, 32'h1C00_0300, 2'b01); flush = 1'b1; #1;
        chk("fi_ready",     32'(req_ready), 32'd0);
        @(negedge clk); clear_inputs(); #1;
        chk("fi_dc_req",    32'(dc_req), 32'd0);
        chk("fi_uc_req",    32'(uc_req), 32'd0);

        // Flush in REQ without addr_ok
        @(negedge clk); issue(1'b0, 2'd2, 4'hF, 32'd0, 32'h1C00_0400, 2'b01); #1;
        @(negedge clk); clear_inputs(); flush = 1'b1; #1;
        chk("fr_c1_dc_req", 32'(dc_req), 32'd1);
        @(negedge clk); flush = 1'b0; #1;
        chk("fr_c2_dc_req", 32'(dc_req), 32'd0);
        chk("fr_c2_ready",  32'(req_ready), 32'd1);
        chk("fr_c2_resp",   32'(resp_valid), 32'd0);

        // Flush in REQ with addr_ok in the same cycle -> DROP
        @(negedge clk); issue(1'b0, 2'd2, 4'hF, 32'd0, 32'h1C00_0500, 2'b01); #1;
        @(negedge clk); clear_inputs(); flush = 1'b1; dc_addr_ok = 1'b1; #1;
        @(negedge clk); clear_inputs(); #1;
        chk("fra_dc_req",   32'(dc_req), 32'd0);
        chk("fra_ready",    32'(req_ready), 32'd0);
        dc_data_ok = 1'b1; dc_rdata = 32'h0BAD_0BAD;
        @(negedge clk); clear_inputs(); #1;
        chk("fra_resp",     32'(resp_valid), 32'd0);
        chk("fra_ready2",   32'(req_ready), 32'd1);

        // Flush in WAIT, data_ok 3 cycles later; then a new uncached load
        @(negedge clk); issue(1'b0, 2'd2, 4'hF, 32'd0, 32'h1C00_0600, 2'b01); #1;
        @(negedge clk); clear_inputs(); dc_addr_ok = 1'b1; #1;
        @(negedge clk); dc_addr_ok = 1'b0; flush = 1'b1; #1;
        @(negedge clk); #1;
        chk("fw_d1_ready",  32'(req_ready), 32'd0);
        chk("fw_d1_resp",   32'(resp_valid), 32'd0);
        @(negedge clk); flush = 1'b0; #1;
        chk("fw_d2_ready",  32'(req_ready), 32'd0);
        @(negedge clk); dc_data_ok = 1'b1; dc_rdata = 32'h7777_7777; #1;
        chk("fw_d3_ready",  32'(req_ready), 32'd0);
        chk("fw_d3_resp",   32'(resp_valid), 32'd0);
        @(negedge clk); clear_inputs(); issue(1'b0, 2'd2, 4'hF, 32'd0, 32'hBFC0_0010, 2'b00); #1;
        chk("fw_idle_resp", 32'(resp_valid), 32'd0);
        chk("fw_idle_ready", 32'(req_ready), 32'd1);
        @(negedge clk); clear_inputs(); uc_addr_ok = 1'b1; #1;
        chk("fw_n_uc_req",  32'(uc_req), 32'd1);
        chk("fw_n_addr",    uc_addr, 32'hBFC0_0010);
        @(negedge clk); clear_inputs(); uc_data_ok = 1'b1; uc_rdata = 32'hCAFE_F00D; #1;
        @(negedge clk); clear_inputs(); #1;
        chk("fw_n_resp",    32'(resp_valid), 32'd1);
        chk("fw_n_rdata",   resp_rdata, 32'hCAFE_F00D);

        // Flush in WAIT together with data_ok -> IDLE, no response
        @(negedge clk); issue(1'b0, 2'd2, 4'hF, 32'd0, 32'h1C00_0700, 2'b01); #1;
        @(negedge clk); clear_inputs(); dc_addr_ok = 1'b1; #1;
        @(negedge clk); clear_inputs(); flush = 1'b1; dc_data_ok = 1'b1; dc_rdata = 32'h1111_2222; #1;
        @(negedge clk); clear_inputs(); #1;
        chk("fwd_resp",     32'(resp_valid), 32'd0);
        chk("fwd_ready",    32'(req_ready), 32'd1);

        // Reset pulsed during WAIT, stale data_ok afterwards
        @(negedge clk); issue(1'b1, 2'd2, 4'hF, 32'hA5A5_A5A5, 32'h1C00_0800, 2'b01); #1;
        @(negedge clk); clear_inputs(); dc_addr_ok = 1'b1; #1;
        @(negedge clk); clear_inputs(); resetn = 1'b0; #1;
        chk("rw_dc_req",    32'(dc_req), 32'd0);
        chk("rw_dc_addr",   dc_addr, 32'd0);
        chk("rw_dc_wdata",  dc_wdata, 32'd0);
        @(negedge clk); resetn = 1'b1; dc_data_ok = 1'b1; dc_rdata = 32'h9999_9999; #1;
        @(negedge clk); clear_inputs(); #1;
        chk("rw_resp",      32'(resp_valid), 32'd0);
        chk("rw_rdata",     resp_rdata, 32'd0);
        chk("rw_ready",     32'(req_ready), 32'd1);
        chk("rw_uc_req",    32'(uc_req), 32'd0);

        // mat=10 load goes uncached; zero-wait slave, back-to-back request
        @(negedge clk); issue(1'b0, 2'd0, 4'h1, 32'd0, 32'h0000_2000, 2'b10); #1;
        @(negedge clk); clear_inputs(); uc_addr_ok = 1'b1; #1;
        chk("m2_uc_req",    32'(uc_req), 32'd1);
        chk("m2_dc_req",    32'(dc_req), 32'd0);
        chk("m2_size",      32'(uc_size), 32'd0);
        @(negedge clk); clear_inputs(); uc_data_ok = 1'b1; uc_rdata = 32'h0000_00A5; #1;
        chk("m2_uc_req2",   32'(uc_req), 32'd0);
        @(negedge clk); clear_inputs(); issue(1'b1, 2'd1, 4'b1100, 32'hAABB_0000, 32'h1C00_0200, 2'b01); #1;
        chk("b2b_resp",     32'(resp_valid), 32'd1);
        chk("b2b_rdata",    resp_rdata, 32'h0000_00A5);
        chk("b2b_ready",    32'(req_ready), 32'd1);
        @(negedge clk); clear_inputs(); dc_addr_ok = 1'b1; #1;
        chk("b2b_dc_req",   32'(dc_req), 32'd1);
        chk("b2b_wstrb",    32'(dc_wstrb), 32'hC);
        chk("b2b_size",     32'(dc_size), 32'd1);
        chk("b2b_wdata",    dc_wdata, 32'hAABB_0000);
        chk("b2b_resp0",    32'(resp_valid), 32'd0);
        @(negedge clk); clear_inputs(); dc_data_ok = 1'b1; dc_rdata = 32'h1234_4321; #1;
        @(negedge clk); clear_inputs(); #1;
        chk("b2b_st_resp",  32'(resp_valid), 32'd1);
        chk("b2b_st_rdata", resp_rdata, 32'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline has a translated access this cycle.
REQ-005 req_ready  output  1  block accepts a request (handshake completes on req_valid & req_ready).
REQ-006 req_wr  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = half, 2 = word.
REQ-008 req_wstrb  input  4  byte-enable for stores.
REQ-009 req_wdata  input  32  store data.
REQ-010 phy_addr  input  32  physical address from address translation.
REQ-011 mat  input  2  memory access type from address translation; 2'b01 = coherent cached, any other value = uncached.
REQ-012 flush  input  1  pipeline flush / exception cancel.
REQ-013 dc_req, dc_wr, dc_size[1:0], dc_wstrb[3:0], dc_addr[31:0], dc_wdata[31:0]  outputs  cached-path request to dcache.
REQ-014 dc_addr_ok, dc_data_ok  inputs  1  dcache address accept / data return; dc_rdata  input  32.
REQ-015 uc_req, uc_wr, uc_size, uc_wstrb, uc_addr, uc_wdata, uc_addr_ok, uc_data_ok, uc_rdata  SHALL have the same widths and meaning as the dc_ ports, for the uncached bus path.
REQ-016 resp_valid  output  1  one-cycle pulse: access complete; resp_rdata  output  32  load data (0 for stores).

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, DROP; at most one access is outstanding.
REQ-018 req_ready SHALL equal (state==IDLE) & ~flush.
REQ-019 On handshake, the block SHALL register wr, size, wstrb, wdata, phy_addr and path select (mat==2'b01 -> cached) and go to REQ.
REQ-020 In REQ, exactly one of dc_req/uc_req (per registered path) SHALL be 1, with the other path's request 0; request fields SHALL be driven from registers and held stable until addr_ok.
REQ-021 The request SHALL first assert in the cycle after the handshake (registered, 1-cycle issue latency).
REQ-022 REQ -> WAIT on the selected path's addr_ok; the request SHALL deassert in the following cycle.
REQ-023 WAIT -> IDLE on the selected path's data_ok; resp_valid SHALL pulse 1 in the next cycle with resp_rdata = registered rdata for loads, 0 for stores.
REQ-024 The block SHALL ignore addr_ok/data_ok on the unselected path and addr_ok outside REQ.
REQ-025 Flush in IDLE: no request accepted that cycle, state stays IDLE.
REQ-026 Flush in REQ without addr_ok: -> IDLE, request deasserted next cycle, no resp_valid.
REQ-027 Flush in REQ with addr_ok the same cycle: -> DROP.
REQ-028 Flush in WAIT without data_ok: -> DROP; flush in WAIT with data_ok the same cycle: -> IDLE, no resp_valid.
REQ-029 DROP: on data_ok -> IDLE, resp_valid stays 0; further flush in DROP has no effect.
REQ-030 resp_valid SHALL never be 1 for two consecutive cycles, and never for a flushed access.
REQ-031 A new request SHALL be accepted in the cycle after resp_valid returns to IDLE (back-to-back throughput: one access per 3 cycles with zero-wait slaves).

Reset
REQ-032 While resetn=0: state=IDLE; dc_req=uc_req=0; resp_valid=0; resp_rdata=0; all registered request fields=0.
REQ-033 Reset asserted mid-access SHALL abandon the access immediately; a data_ok arriving after reset release with state IDLE SHALL be ignored.

Verification
REQ-034 Cached load: phy_addr=0x1C00_0100, mat=01, dc_addr_ok at cycle 2, dc_data_ok with dc_rdata=0xDEAD_BEEF at cycle 4 -> dc_req=1 in cycles 1-2, resp_valid=1 at cycle 5 with 0xDEAD_BEEF, uc_req never 1.
REQ-035 Uncached store: mat=00, addr 0xBFAF_F000, wstrb=4'b0011, wdata=0x1234_5678 -> uc_req with identical fields held until uc_addr_ok, resp_valid=1 with resp_rdata=0.
REQ-036 Flush in REQ with addr_ok 0 -> request dropped next cycle, FSM IDLE, no resp_valid; req_ready=1 the following cycle.
REQ-037 Flush in WAIT, data_ok 3 cycles later -> DROP held 3 cycles, no resp_valid, next request accepted after return to IDLE.
REQ-038 resetn pulsed low during WAIT, stale dc_data_ok after release -> all outputs 0, no resp_valid, FSM IDLE.
REQ-039 mat=2'b10 load -> routed to uc_ path, dc_req stays 0.
